// File: rtl/asu_ddr5_dqs_pattern_gen.sv
// ---------------------------------------------------------------------------
// asu_ddr5_dqs_pattern_gen
//
// DQS pattern generator for the DDR5 write FSM. For the preamble, interamble
// and postamble phases it supplies the per-cycle 2-bit DQS pattern, a
// pattern-valid flag and the end-of-phase done strobes. All outputs are
// combinational from registered state plus the phase inputs, so the FSM sees
// them in the same cycle it enters a phase.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   enable_i                block enable; low freezes every register
//   *_state_i               phase decode of the write FSM state
//   preamble_sel_i          00=2tCK 01=3tCK 10=4tCK 11=reserved (as 2tCK)
//   postamble_sel_i         0=1 cycle, 1=2 cycles
//   gap_i                   write-enable-low gap, sizes the interamble
//   preamble_bits_o/valid_o/done_o, interamble_bits_o/done_o,
//   postamble_done_o        pattern and strobes back to the FSM
//   pattern_err_o           sticky error flag
//
// Build option: define ASU_DDR5_DQS_ERR_EN to include the sticky error flag
// (overlapping phase inputs, or preamble entered with the reserved select).
// Without it pattern_err_o is tied to 0.
//
// state (phase_q) | meaning
//   PH_NONE       | no phase active last cycle; selects are captured
//   PH_PRE        | preamble active last cycle
//   PH_INTER      | interamble active last cycle
//   PH_POST       | postamble active last cycle
// ---------------------------------------------------------------------------
module asu_ddr5_dqs_pattern_gen #(
    parameter int pMAX_PRE_LEN = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       preamble_state_i,
    input  logic       interamble_state_i,
    input  logic       postamble_state_i,
    input  logic [1:0] preamble_sel_i,
    input  logic       postamble_sel_i,
    input  logic [3:0] gap_i,
    output logic [1:0] preamble_bits_o,
    output logic       preamble_valid_o,
    output logic       preamble_done_o,
    output logic [1:0] interamble_bits_o,
    output logic       interamble_done_o,
    output logic       postamble_done_o,
    output logic       pattern_err_o
);

    localparam int CW = $clog2(pMAX_PRE_LEN) + 1;

    typedef enum logic [1:0] {PH_NONE, PH_PRE, PH_INTER, PH_POST} phase_t;

    phase_t          phase, phase_q;
    logic [CW-1:0]   cnt_q, cnt_eff, cnt_nxt;
    logic [1:0]      sel_q;
    logic            post_q;
    logic [CW-1:0]   ilen_q, ilen_eff, l_comb;
    logic [CW-1:0]   n_len, len, last;
    logic [CW-1:0]   iidx;

    // Pattern table: 2tCK 00,10 / 3tCK 00,00,10 / 4tCK 00,00,10,10.
    function automatic logic [1:0] pat_bits(input logic [1:0] sel, input logic [CW-1:0] idx);
        case (sel)
            2'b01:   return (idx == CW'(2)) ? 2'b10 : 2'b00;
            2'b10:   return (idx >= CW'(2)) ? 2'b10 : 2'b00;
            default: return (idx == CW'(1)) ? 2'b10 : 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= PH_NONE;
            cnt_q   <= '0;
            sel_q   <= 2'b00;
            post_q  <= 1'b0;
            ilen_q  <= CW'(1);
        end else if (enable_i) begin
            phase_q <= phase;
            cnt_q   <= cnt_nxt;
            if (phase == PH_NONE) begin
                sel_q  <= preamble_sel_i;
                post_q <= postamble_sel_i;
            end
            if (phase == PH_INTER && cnt_eff == '0)
                ilen_q <= l_comb;
        end
    end

    always_comb begin
        phase             = PH_NONE;
        cnt_eff           = '0;
        n_len             = CW'(2);
        l_comb            = CW'(1);
        ilen_eff          = ilen_q;
        len               = CW'(1);
        last              = '0;
        cnt_nxt           = '0;
        iidx              = '0;
        preamble_bits_o   = 2'b00;
        preamble_valid_o  = 1'b0;
        preamble_done_o   = 1'b0;
        interamble_bits_o = 2'b00;
        interamble_done_o = 1'b0;
        postamble_done_o  = 1'b0;

        if (preamble_state_i)        phase = PH_PRE;
        else if (interamble_state_i) phase = PH_INTER;
        else if (postamble_state_i)  phase = PH_POST;

        // A phase change (including a direct one) restarts at index 0.
        if (phase == phase_q) cnt_eff = cnt_q;

        case (sel_q)
            2'b01:   n_len = CW'(3);
            2'b10:   n_len = CW'(4);
            default: n_len = CW'(2);
        endcase

        if (gap_i == 4'd0)             l_comb = CW'(1);
        else if (gap_i > 4'(n_len))    l_comb = n_len;
        else                           l_comb = CW'(gap_i);

        // The interamble length is only sized on its first cycle.
        ilen_eff = (cnt_eff == '0) ? l_comb : ilen_q;

        case (phase)
            PH_PRE:   len = n_len;
            PH_INTER: len = ilen_eff;
            PH_POST:  len = post_q ? CW'(2) : CW'(1);
            default:  len = CW'(1);
        endcase
        last = len - CW'(1);

        if (phase != PH_NONE)
            cnt_nxt = (cnt_eff >= last) ? last : cnt_eff + CW'(1);

        // Interamble replays the tail of the selected preamble pattern.
        iidx = n_len - ilen_eff + cnt_eff;

        case (phase)
            PH_PRE: begin
                preamble_bits_o  = pat_bits(sel_q, cnt_eff);
                preamble_valid_o = 1'b1;
                preamble_done_o  = (cnt_eff == last);
            end
            PH_INTER: begin
                interamble_bits_o = pat_bits(sel_q, iidx);
                interamble_done_o = (cnt_eff == last);
            end
            PH_POST: postamble_done_o = (cnt_eff == last);
            default: ;
        endcase
    end

`ifdef ASU_DDR5_DQS_ERR_EN
    logic err_q;
    logic multi_phase;
    logic rsv_entry;

    assign multi_phase = (preamble_state_i & interamble_state_i) |
                         (preamble_state_i & postamble_state_i)  |
                         (interamble_state_i & postamble_state_i);
    assign rsv_entry   = (phase == PH_PRE) && (phase_q != PH_PRE) && (sel_q == 2'b11);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            err_q <= 1'b0;
        else if (enable_i && (multi_phase || rsv_entry))
            err_q <= 1'b1;
    end

    assign pattern_err_o = err_q;
`else
    assign pattern_err_o = 1'b0;
`endif

endmodule
